vend_sequencer: RTL
===================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 The block SHALL have parameter PRICE, default 15, meaning item price in TK; legal values are multiples of 5 in the range 5..60.
REQ-002 The block SHALL have parameter MAX_CREDIT, default 40, meaning the credit ceiling in TK; legal values are multiples of 5, at least PRICE and at most 60.
REQ-003 The block SHALL have parameter TIMEOUT, default 200, meaning the number of idle cycles in CREDIT before auto-refund; legal range is 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port coin_valid, input, 1 bit: a coin is presented this cycle.
REQ-007 The block SHALL have port cash_in, input, 2 bits: coin code, 01=5, 10=10, 11=20 TK; 00 with coin_valid high is ignored.
REQ-008 The block SHALL have port sel, input, 1 bit: purchase request pulse.
REQ-009 The block SHALL have port cancel, input, 1 bit: refund request pulse.
REQ-010 The block SHALL have port dispense_ack, input, 1 bit: the dispenser has completed the item.
REQ-011 The block SHALL have port coin_out_ack, input, 1 bit: the change hopper has taken the presented coin.
REQ-012 The block SHALL have port dispense_req, output, 1 bit: item dispense request, held until acknowledged.
REQ-013 The block SHALL have port coin_out_valid, output, 1 bit: a change coin is presented.
REQ-014 The block SHALL have port coin_out, output, 2 bits: change coin code, with the same encoding as cash_in.
REQ-015 The block SHALL have port coin_reject, output, 1 bit: a one-cycle pulse indicating the presented coin was not accepted.
REQ-016 The block SHALL have port credit, output, 6 bits: the current credit in TK, unsigned.
REQ-017 The block SHALL have port busy, output, 1 bit: high in the VEND or CHANGE state.

Function
REQ-018 The FSM SHALL have states IDLE (credit=0), CREDIT (credit>0), VEND and CHANGE, with the state registered.
REQ-019 In IDLE or CREDIT, a valid coin with credit+coin<=MAX_CREDIT SHALL add the coin value to credit on the next edge and move to CREDIT.
REQ-020 A valid coin with credit+coin>MAX_CREDIT, or any valid coin in VEND or CHANGE, SHALL leave credit unchanged and pulse coin_reject high for exactly one cycle, one cycle after the coin is presented.
REQ-021 sel in CREDIT with credit>=PRICE SHALL subtract PRICE from credit and enter VEND on the next edge; sel with credit<PRICE SHALL be ignored with no error output.
REQ-022 When sel and an accepted coin occur in the same cycle, the sufficiency test SHALL use the pre-coin credit, and credit_next SHALL equal credit+coin-PRICE; the overflow test SHALL use credit+coin.
REQ-023 cancel SHALL take priority over sel, and a coin in the same cycle as cancel SHALL be rejected.
REQ-024 cancel in CREDIT SHALL enter CHANGE; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-025 In VEND, dispense_req SHALL be high from the first VEND cycle until the cycle dispense_ack is sampled high; dispense_ack outside VEND SHALL be ignored.
REQ-026 On dispense_ack in VEND, the block SHALL go to CHANGE if credit>0, else to IDLE, with dispense_req low on the next cycle.
REQ-027 In CHANGE, coin_out_valid SHALL be high with the greedy largest coin not exceeding credit (20, then 10, then 5), and coin_out SHALL hold stable until coin_out_ack.
REQ-028 On coin_out_ack, credit SHALL be reduced by the coin value, and the next coin SHALL be presented the following cycle with no bubble.
REQ-029 When credit reaches 0 in CHANGE, the block SHALL enter IDLE with coin_out_valid low.
REQ-030 coin_out_ack while coin_out_valid is low SHALL be ignored.
REQ-031 The idle counter SHALL be 8 bits, reset to 0 on any accepted coin, sel or cancel in CREDIT, and incremented otherwise while in CREDIT.
REQ-032 When the idle counter reaches TIMEOUT, the block SHALL enter CHANGE as for cancel.
REQ-033 The idle counter SHALL be cleared on leaving CREDIT and SHALL never wrap.
REQ-034 credit SHALL never exceed MAX_CREDIT and never underflow; all arithmetic SHALL be 6-bit unsigned.
REQ-035 The outputs credit and busy SHALL be registered.

Reset
REQ-036 When rst is high at a clock edge, the block SHALL enter IDLE, set credit=0 and the idle counter to 0, and drive dispense_req, coin_out_valid, coin_out, coin_reject and busy to 0 on the next cycle.
REQ-037 Reset asserted mid-VEND or mid-CHANGE SHALL abandon the transaction with no refund, and inputs SHALL be ignored while rst is high.

Verification
REQ-038 The bench SHALL cover a coin sequence 10, 5, then sel with PRICE=15: credit 10->15, then dispense_req high, ack, and back to IDLE with credit 0 and no coin_out.
REQ-039 The bench SHALL cover coins 20, 20, then sel: credit 40, then 25 after sel; after dispense_ack, coin_out=11 (20) then 01 (5), each held until its ack, ending in IDLE.
REQ-040 The bench SHALL cover credit 35 plus a 10 coin: coin_reject pulses for one cycle and credit stays 35.
REQ-041 The bench SHALL cover sel with a 5 coin in the same cycle at credit 10: sel is ignored and credit becomes 15.
REQ-042 The bench SHALL cover sel with a 5 coin in the same cycle at credit 15: VEND is entered and credit becomes 5.
REQ-043 The bench SHALL cover a coin of 10 followed by TIMEOUT idle cycles: CHANGE is entered with coin_out=10; a separate case with cancel and sel in the same cycle enters CHANGE.
REQ-044 The bench SHALL cover rst pulsed while dispense_req is high: the next cycle shows IDLE with all outputs 0 and dispense_ack ignored.

Source files
------------

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-operated vending controller with greedy change payout,
// idle auto-refund and registered handshake outputs.
`default_nettype none

module vend_sequencer #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 40,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] cash_in,
    input  logic       sel,
    input  logic       cancel,
    input  logic       dispense_ack,
    input  logic       coin_out_ack,
    output logic       dispense_req,
    output logic       coin_out_valid,
    output logic [1:0] coin_out,
    output logic       coin_reject,
    output logic [5:0] credit,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [5:0] c_PRICE   = 6'(PRICE);
    localparam logic [6:0] c_MAX     = 7'(MAX_CREDIT);
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    function automatic logic [5:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   coin_value = 6'd5;
            2'b10:   coin_value = 6'd10;
            2'b11:   coin_value = 6'd20;
            default: coin_value = 6'd0;
        endcase
    endfunction

    function automatic logic [1:0] greedy_coin(input logic [5:0] amount);
        if (amount >= 6'd20)      greedy_coin = 2'b11;
        else if (amount >= 6'd10) greedy_coin = 2'b10;
        else                      greedy_coin = 2'b01;
    endfunction

    state_t     r_state;
    logic [7:0] r_idle_cnt;

    state_t     w_state_n;
    logic [5:0] w_credit_n;
    logic [7:0] w_idle_n;
    logic       w_dreq_n;
    logic       w_cov_n;
    logic [1:0] w_co_n;
    logic       w_rej_n;

    logic       w_coin_present;
    logic [5:0] w_coin_val;
    logic [6:0] w_sum;
    logic       w_accept;
    logic [5:0] w_remain;
    logic [7:0] w_idle_inc;

    // One extra bit on the sum so a 20 on top of a full 60 cannot wrap past the ceiling test.
    assign w_coin_present = coin_valid && (cash_in != 2'b00);
    assign w_coin_val     = coin_value(cash_in);
    assign w_sum          = {1'b0, credit} + {1'b0, w_coin_val};
    assign w_accept       = w_coin_present && !cancel && (w_sum <= c_MAX);
    assign w_remain       = credit - coin_value(coin_out);
    assign w_idle_inc     = r_idle_cnt + 8'd1;

    always_comb begin
        w_state_n  = r_state;
        w_credit_n = credit;
        w_idle_n   = r_idle_cnt;
        w_dreq_n   = dispense_req;
        w_cov_n    = coin_out_valid;
        w_co_n     = coin_out;
        w_rej_n    = 1'b0;

        case (r_state)
            S_IDLE, S_CREDIT: begin
                w_rej_n = w_coin_present && !w_accept;
                if (r_state == S_CREDIT && cancel) begin
                    w_state_n = S_CHANGE;
                    w_idle_n  = 8'd0;
                    w_cov_n   = 1'b1;
                    w_co_n    = greedy_coin(credit);
                end else if (r_state == S_CREDIT && sel && credit >= c_PRICE) begin
                    // Sufficiency is judged on the pre-coin credit; an accepted coin still adds in.
                    w_credit_n = (w_accept ? w_sum[5:0] : credit) - c_PRICE;
                    w_state_n  = S_VEND;
                    w_idle_n   = 8'd0;
                    w_dreq_n   = 1'b1;
                end else if (w_accept) begin
                    w_credit_n = w_sum[5:0];
                    w_state_n  = S_CREDIT;
                    w_idle_n   = 8'd0;
                end else if (r_state == S_CREDIT) begin
                    if (sel || cancel) begin
                        w_idle_n = 8'd0;
                    end else if (w_idle_inc >= c_TIMEOUT) begin
                        w_state_n = S_CHANGE;
                        w_idle_n  = 8'd0;
                        w_cov_n   = 1'b1;
                        w_co_n    = greedy_coin(credit);
                    end else begin
                        w_idle_n = w_idle_inc;
                    end
                end
            end
            S_VEND: begin
                w_rej_n = w_coin_present;
                if (dispense_ack) begin
                    w_dreq_n = 1'b0;
                    if (credit != 6'd0) begin
                        w_state_n = S_CHANGE;
                        w_cov_n   = 1'b1;
                        w_co_n    = greedy_coin(credit);
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_rej_n = w_coin_present;
                if (coin_out_ack && coin_out_valid) begin
                    w_credit_n = w_remain;
                    if (w_remain == 6'd0) begin
                        w_state_n = S_IDLE;
                        w_cov_n   = 1'b0;
                        w_co_n    = 2'b00;
                    end else begin
                        w_co_n = greedy_coin(w_remain);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idle_cnt     <= 8'd0;
            credit         <= 6'd0;
            dispense_req   <= 1'b0;
            coin_out_valid <= 1'b0;
            coin_out       <= 2'b00;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_idle_cnt     <= w_idle_n;
            credit         <= w_credit_n;
            dispense_req   <= w_dreq_n;
            coin_out_valid <= w_cov_n;
            coin_out       <= w_co_n;
            coin_reject    <= w_rej_n;
            busy           <= (w_state_n == S_VEND) || (w_state_n == S_CHANGE);
        end
    end

endmodule

`default_nettype wire
